// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encodings, fetch word layout and the
// canonical bubble instruction reused by downstream flush logic.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the fetch PC, issues one outstanding imem request at a time
// and drives the IF/ID register, dropping responses made stale by a redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pcPlus4,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
);

  localparam if_id_t BUBBLE = '{pc: 32'd0, pc_plus4: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_word_t  hold_q, hold_d;
  if_id_t       if_id_q, if_id_d;
  logic         deliver;
  fetch_word_t  deliver_word;
  logic         req_fire;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      if_id_q <= BUBBLE;
    end else begin
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      if_id_q <= if_id_d;
    end
  end

  assign req_fire = imem_req_valid && imem_req_ready;

  // Next-state and PC logic; a redirect always wins so it is never lost.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    deliver      = 1'b0;
    deliver_word = hold_q;
    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = PCSrc ? S_KILL : S_WAIT;
        if (PCSrc)    pc_d    = PCTarget;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (PCSrc) begin
            pc_d    = PCTarget;
            state_d = S_REQ;
          end else if (StallD) begin
            hold_d  = '{pc: pc_q, instr: imem_rsp_data};
            state_d = S_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = '{pc: pc_q, instr: imem_rsp_data};
            pc_d         = pc_plus4(pc_q);
            state_d      = S_REQ;
          end
        end else if (PCSrc) begin
          pc_d    = PCTarget;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (PCSrc)          pc_d    = PCTarget;
        if (imem_rsp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (PCSrc) begin
          pc_d    = PCTarget;
          state_d = S_REQ;
        end else if (!StallD) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
          pc_d         = pc_plus4(pc_q);
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID priority: flush > stall > new instruction > bubble.
  always_comb begin
    if_id_d = BUBBLE;
    if (FlushD)       if_id_d = BUBBLE;
    else if (StallD)  if_id_d = if_id_q;
    else if (deliver) if_id_d = '{pc:       deliver_word.pc,
                                  pc_plus4: pc_plus4(deliver_word.pc),
                                  instr:    deliver_word.instr,
                                  valid:    1'b1};
  end

  // Output logic
  always_comb begin
    imem_req_valid = rst_n && (state_q == S_REQ) && !StallF;
  end

  assign imem_addr     = pc_q;
  assign IF_ID_pc      = if_id_q.pc;
  assign IF_ID_pcPlus4 = if_id_q.pc_plus4;
  assign IF_ID_instr   = if_id_q.instr;
  assign IF_ID_valid   = if_id_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small latency-programmable imem
// model; words are C0DE_0000 ^ address so every fetched word is identifiable.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] IF_ID_pc, IF_ID_pcPlus4, IF_ID_instr;
  logic        IF_ID_valid;

  int n_checks = 0;
  int n_errors = 0;

  // memory model state
  int          lat = 1;
  int          cnt = 0;
  bit          pending = 0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IF_ID_pc       (IF_ID_pc),
    .IF_ID_pcPlus4  (IF_ID_pcPlus4),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_valid    (IF_ID_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".pc"},    IF_ID_pc,      pc);
    check({tag, ".pc4"},   IF_ID_pcPlus4, pc4);
    check({tag, ".instr"}, IF_ID_instr,   instr);
    check({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
  endtask

  // One clock: entered at a negedge with inputs already set, returns at the next negedge.
  task automatic tick();
    bit          acc;
    bit          rst_s;
    logic [31:0] a;
    #1;
    acc   = imem_req_valid && imem_req_ready;
    a     = imem_addr;
    rst_s = rst_n;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      pending        = 0;
      imem_rsp_valid = 1'b0;
    end else begin
      if (imem_rsp_valid) begin
        imem_rsp_valid = 1'b0;
        pending        = 0;
      end
      if (acc) begin
        pending = 1;
        cnt     = lat;
        paddr   = a;
      end
      if (pending && !imem_rsp_valid) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hC0DE_0000 ^ paddr;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrc = 1'b0;
    PCTarget = '0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    tick(); tick();

    // Reset state
    check_ifid("reset", 32'h0, 32'h0, 32'h13, 1'b0);
    check("reset.req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b1; settle();
    check("rel.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rel.addr", imem_addr, 32'h0);

    // Streaming with 1-cycle latency
    tick();
    check("s1.valid_low", {31'd0, IF_ID_valid}, 32'd0);
    check("s1.req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check_ifid("s2", 32'h0, 32'h4, 32'hC0DE_0000, 1'b1);
    check("s2.addr", imem_addr, 32'h4);
    tick();
    check("s3.bubble", {31'd0, IF_ID_valid}, 32'd0);
    tick();
    check_ifid("s4", 32'h4, 32'h8, 32'hC0DE_0004, 1'b1);
    check("s4.addr", imem_addr, 32'h8);

    // Redirect while waiting on a 3-cycle response
    lat = 3;
    tick();                                  // accept 0x8
    PCSrc = 1'b1; PCTarget = 32'h0000_0100;
    tick();
    PCSrc = 1'b0; settle();
    check("kill.req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("kill.addr", imem_addr, 32'h100);
    tick();
    tick();                                  // stale response discarded here
    check("kill.valid", {31'd0, IF_ID_valid}, 32'd0);
    check("kill.req_valid2", {31'd0, imem_req_valid}, 32'd1);
    check("kill.addr2", imem_addr, 32'h100);
    lat = 1;

    // Response under StallD lands in the hold buffer
    tick(); tick();
    check_ifid("st0", 32'h100, 32'h104, 32'hC0DE_0100, 1'b1);
    StallD = 1'b1;
    tick(); tick(); tick();
    check_ifid("st3", 32'h100, 32'h104, 32'hC0DE_0100, 1'b1);
    check("st3.req_valid", {31'd0, imem_req_valid}, 32'd0);
    StallD = 1'b0;
    tick();
    check_ifid("st4", 32'h104, 32'h108, 32'hC0DE_0104, 1'b1);
    check("st4.addr", imem_addr, 32'h108);
    check("st4.req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Flush beats stall
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    check_ifid("flush", 32'h0, 32'h0, 32'h13, 1'b0);
    FlushD = 1'b0; StallD = 1'b0;
    tick();
    check_ifid("flush.next", 32'h108, 32'h10C, 32'hC0DE_0108, 1'b1);

    // Redirect without acceptance, then PC wrap at the top of memory
    imem_req_ready = 1'b0; PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    tick();
    imem_req_ready = 1'b1; PCSrc = 1'b0; settle();
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 32'h3F21_FFFC, 1'b1);
    check("wrap.next_addr", imem_addr, 32'h0);

    // StallF suppresses the request and freezes the PC
    StallF = 1'b1; settle();
    check("stallf.req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick(); tick();
    check("stallf.req_valid2", {31'd0, imem_req_valid}, 32'd0);
    check("stallf.addr", imem_addr, 32'h0);
    StallF = 1'b0;

    // Reset while a request is outstanding
    tick(); tick();
    check_ifid("pre_rst", 32'h0, 32'h4, 32'hC0DE_0000, 1'b1);
    tick();                                  // accept 0x4, now waiting
    check("pre_rst.addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    tick();
    check_ifid("mid_rst", 32'h0, 32'h0, 32'h13, 1'b0);
    check("mid_rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b1; settle();
    check("mid_rst.addr", imem_addr, 32'h0);
    check("mid_rst.req_valid2", {31'd0, imem_req_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
